// File: rtl/mem_controller_pkg.sv
// Shared constants, core-control condition codes and controller state encoding.
package mem_controller_pkg;

  localparam int MC_DATA_W = 32;
  localparam int MC_ADDR_W = 6;
  localparam int MC_DEPTH  = 1 << MC_ADDR_W;

  // mc_data_condition = {HAS_DATA, VALID_DATA, HAS_DATA_R, VALID_DATA_R}
  localparam logic [3:0] COND_IDLE   = 4'b0000;
  localparam logic [3:0] COND_STORED = 4'b1100;
  localparam logic [3:0] COND_PROC   = 4'b1111;
  localparam logic [3:0] COND_DONE   = 4'b1110;

  typedef enum logic [2:0] {
    MC_IDLE,
    MC_STORE,
    MC_LOAD_A,
    MC_LOAD_B,
    MC_READY,
    MC_PROC,
    MC_CHECK
  } mc_state_e;

endpackage

// File: rtl/mem_controller_if.sv
// Core-control / FPU facing bus of the memory controller.
interface mem_controller_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              mc_we;
  logic [ADDR_W-1:0] mc_addr_in;
  logic [3:0]        mc_data_condition;
  logic [DATA_W-1:0] mc_din;
  logic              mc_din_valid;
  logic [DATA_W-1:0] mc_opa;
  logic [DATA_W-1:0] mc_opb;
  logic              mc_op_valid;
  logic              mc_err;
  logic              mc_cont_procc;
  logic              mc_data_done;
  logic [ADDR_W:0]   mc_count;

  modport master (
    output mc_we, mc_addr_in, mc_data_condition, mc_din, mc_din_valid,
    input  mc_opa, mc_opb, mc_op_valid, mc_err, mc_cont_procc, mc_data_done, mc_count
  );

  modport slave (
    input  mc_we, mc_addr_in, mc_data_condition, mc_din, mc_din_valid,
    output mc_opa, mc_opb, mc_op_valid, mc_err, mc_cont_procc, mc_data_done, mc_count
  );
endinterface

// File: rtl/mc_regfile.sv
// Operand buffer: one write port, one registered read port, contents not reset.
module mc_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              mc_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge mc_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_controller.sv
// Buffers operand words, hands A/B pairs to the FPU and returns the core handshake flags.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int DATA_W = MC_DATA_W,
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DEPTH  = MC_DEPTH
) (
  input  logic           mc_clk,
  input  logic           mc_reset,
  mem_controller_if.slave bus
);

  localparam int CNT_W = ADDR_W + 1;

  mc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, wr_addr, rd_addr;
  logic [CNT_W-1:0]  count_q, consumed_q, pairs_left, pairs_after;
  logic [DATA_W-1:0] opa_q, opb_q, rdata;
  logic              op_valid_q, err_q, more_q, done_q, cont;
  logic              start_sess, do_wr, ovf, xfer_err, abort, load_a, load_b, to_check;
  logic [3:0]        cond;

  assign cond        = bus.mc_data_condition;
  assign pairs_left  = (count_q - consumed_q) >> 1;
  assign pairs_after = (count_q - consumed_q - CNT_W'(2)) >> 1;

  mc_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_regfile (
    .mc_clk (mc_clk),
    .we     (do_wr),
    .waddr  (wr_addr),
    .wdata  (bus.mc_din),
    .raddr  (rd_addr),
    .rdata  (rdata)
  );

  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) state_q <= MC_IDLE;
    else           state_q <= state_d;
  end

  // The read port is registered, so the A address is presented in the cycle the
  // request is accepted and the B address during MC_LOAD_A.
  always_comb begin
    state_d    = state_q;
    start_sess = 1'b0;
    do_wr      = 1'b0;
    ovf        = 1'b0;
    xfer_err   = 1'b0;
    abort      = 1'b0;
    wr_addr    = wr_ptr_q;
    rd_addr    = rd_ptr_q;
    case (state_q)
      MC_IDLE: begin
        if (bus.mc_we) begin
          start_sess = 1'b1;
          do_wr      = bus.mc_din_valid;
          wr_addr    = bus.mc_addr_in;
          state_d    = MC_STORE;
        end
      end
      MC_STORE: begin
        if (bus.mc_we) begin
          if (bus.mc_din_valid) begin
            if (count_q == CNT_W'(DEPTH)) ovf = 1'b1;
            else                          do_wr = 1'b1;
          end
        end else if (cond == COND_STORED) begin
          if (pairs_left == '0) xfer_err = 1'b1;
          else                  state_d  = MC_LOAD_A;
        end
      end
      MC_LOAD_A: begin
        rd_addr = rd_ptr_q + ADDR_W'(1);
        state_d = MC_LOAD_B;
      end
      MC_LOAD_B: state_d = MC_READY;
      MC_READY:  if (cond == COND_PROC) state_d = MC_PROC;
      MC_PROC:   if (cond == COND_DONE) state_d = MC_CHECK;
      MC_CHECK: begin
        if (cond == COND_STORED) begin
          if (pairs_left == '0) xfer_err = 1'b1;
          else                  state_d  = MC_LOAD_A;
        end
      end
      default: state_d = MC_IDLE;
    endcase
    if (state_q != MC_IDLE && state_q != MC_STORE && cond == COND_IDLE) begin
      abort   = 1'b1;
      state_d = MC_IDLE;
    end
  end

  assign load_a   = (state_q == MC_LOAD_A) && !abort;
  assign load_b   = (state_q == MC_LOAD_B) && !abort;
  assign to_check = (state_q == MC_PROC) && (state_d == MC_CHECK);

  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      consumed_q <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      op_valid_q <= 1'b0;
      err_q      <= 1'b0;
      more_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (start_sess) begin
        wr_ptr_q   <= bus.mc_addr_in + ADDR_W'(do_wr);
        rd_ptr_q   <= bus.mc_addr_in;
        count_q    <= CNT_W'(do_wr);
        consumed_q <= '0;
        err_q      <= 1'b0;
        more_q     <= 1'b0;
        done_q     <= 1'b0;
        op_valid_q <= 1'b0;
      end
      if (do_wr && state_q == MC_STORE) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        count_q  <= count_q + CNT_W'(1);
      end
      if (ovf || xfer_err) err_q <= 1'b1;
      if (xfer_err)        done_q <= 1'b1;
      if (load_a)          opa_q <= rdata;
      if (load_b) begin
        opb_q      <= rdata;
        rd_ptr_q   <= rd_ptr_q + ADDR_W'(2);
        consumed_q <= consumed_q + CNT_W'(2);
        more_q     <= (pairs_after != '0);
        done_q     <= (pairs_after == '0);
        op_valid_q <= 1'b1;
      end
      if (to_check) op_valid_q <= 1'b0;
      // Session end keeps the operands and the error flag for the core to inspect.
      if (abort) begin
        op_valid_q <= 1'b0;
        more_q     <= 1'b0;
        done_q     <= 1'b0;
      end
    end
  end

  always_comb begin
    case (cond)
      COND_STORED: cont = op_valid_q;
      COND_DONE:   cont = more_q;
      default:     cont = 1'b0;
    endcase
  end

  assign bus.mc_opa        = opa_q;
  assign bus.mc_opb        = opb_q;
  assign bus.mc_op_valid   = op_valid_q;
  assign bus.mc_err        = err_q;
  assign bus.mc_cont_procc = cont;
  assign bus.mc_data_done  = done_q;
  assign bus.mc_count      = count_q;

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Memory controller directly downstream of the core control FSM.
- Buffers operand words from the input stream into a 64-entry register-file memory while write-enable is high.
- On each transfer request, loads operand pairs (A, B) into output registers for the FPU processing unit.
- Returns the handshake flags (mc_err, mc_cont_procc, mc_data_done) that advance the core control FSM.

Parameters:
DATA_W, 32, operand word width
ADDR_W, 6, address width; matches the core control address bus
DEPTH, 64, memory entries; equals 2**ADDR_W

Ports:
mc_clk  in  1  clock
mc_reset  in  1  asynchronous, active-low reset
mc_we  in  1  write-enable level from core control (store phase)
mc_addr_in  in  ADDR_W  start address from core control; sampled when the store phase begins
mc_data_condition  in  4  [HAS_DATA|VALID_DATA|HAS_DATA_R|VALID_DATA_R] from core control
mc_din  in  DATA_W  operand input word
mc_din_valid  in  1  mc_din valid this cycle
mc_opa  out  DATA_W  operand A register
mc_opb  out  DATA_W  operand B register
mc_op_valid  out  1  operands loaded and held for processing
mc_err  out  1  sticky error: overflow, or transfer requested with no complete pair
mc_cont_procc  out  1  operands ready / more pairs pending
mc_data_done  out  1  no complete pair remains unread
mc_count  out  ADDR_W+1  words stored this session

Behaviour:
- Reset (mc_reset=0, asynchronous):
  - All outputs 0.
  - Pointers 0, count 0, state MC_IDLE.
  - Memory contents are not reset.
  - Reset mid-operation aborts immediately; no partial pair is presented after release.
- States: MC_IDLE, MC_STORE, MC_LOAD_A, MC_LOAD_B, MC_READY, MC_PROC, MC_CHECK.
- MC_IDLE:
  - mc_we=1: base=wr_ptr=rd_ptr=mc_addr_in, count=0, mc_err cleared, go to MC_STORE.
  - If mc_din_valid is also 1 that cycle, the word is written at mc_addr_in and count=1.
- MC_STORE:
  - Each cycle with mc_we & mc_din_valid: mem[wr_ptr]<=mc_din, wr_ptr+1 (wraps DEPTH-1 to 0), count+1.
  - Write with count==DEPTH: word dropped, mc_err<=1, no pointer change.
  - mc_we falling: stay until mc_data_condition==1100.
- Transfer request (condition 1100):
  - If pairs_left = (count - consumed)>>1 is 0: mc_err<=1, mc_data_done<=1, remain. No load occurs.
  - Otherwise MC_LOAD_A: mc_opa<=mem[rd_ptr].
  - Next cycle, MC_LOAD_B: mc_opb<=mem[rd_ptr+1], rd_ptr+=2 (mod DEPTH), consumed+=2.
  - Next cycle, MC_READY: mc_op_valid<=1.
  - Latency from first 1100 cycle to mc_cont_procc=1 is 3 cycles.
- mc_cont_procc (registered state, decoded with the condition input):
  - = mc_op_valid while condition is 1100.
  - = more_q while condition is 1110.
  - = 0 otherwise.
  - more_q is a register = (pairs_left != 0), updated when MC_LOAD_B completes.
- mc_data_done: registered, = !more_q. Valid before the core enters DONE_PROC, so the core samples it in its first DONE_PROC cycle.
- Condition 1111 (MC_PROC): operands held stable, mc_op_valid=1.
- Condition 1110 (MC_CHECK): mc_op_valid<=0; operand registers keep their value.
  - Next 1100 starts the next load.
  - 0000 returns to MC_IDLE.
- Condition 0000 from any state other than MC_STORE or MC_IDLE: return to MC_IDLE.
  - mc_cont_procc and mc_data_done are cleared.
  - mc_err is retained until the next store phase starts.
- Odd word count: the final unpaired word is never loaded and does not assert mc_err.
- Simultaneous mc_we=1 and a non-zero condition: mc_we has priority; the condition is ignored.

Decomposition:
- Shared package: condition encodings (COND_IDLE 0000, COND_STORED 1100, COND_PROC 1111, COND_DONE 1110), MC state encodings, ADDR_W/DEPTH constants.
- One sub-module, mc_regfile: DEPTH x DATA_W array, one write port, one synchronous read port, no reset.

Test Plan:
- Store 4 words 0x3F800000, 0x40000000, 0x40400000, 0x40800000 at address 0x10, then 1100.
  -> opa=0x3F800000, opb=0x40000000, mc_cont_procc=1 three cycles after 1100; mc_data_done=0.
- Continue with 1111, 1110, then 1100.
  -> mc_cont_procc=1 during 1110; second pair 0x40400000/0x40800000 loaded; mc_data_done=1 at the next 1110.
- Store starting at address 62 with 4 words.
  -> writes land at 62, 63, 0, 1 (wrap); second pair is read from 0/1.
- Write 65 words.
  -> mc_count=64, mc_err=1 on the 65th word, mem[base] unchanged.
- Store 1 word, then 1100.
  -> mc_err=1, mc_data_done=1, mc_cont_procc=0, no load occurs.
- Assert reset during MC_LOAD_B.
  -> all outputs 0 asynchronously; after release, mc_we starts a clean session with count=0.
